vblank_arbiter: RTL
===================

// Module: vblank_arbiter
// PURPOSE
// - Shares the single update window of each frame (vertical blank) between N_REQ requesters
//   (note-lane RAM writer, score writer, sprite loader, ...) that must not touch display
//   memory while lines are visible.
// - Consumes the vertical timer's blank/y-coordinate outputs and issues one-hot grants
//   round-robin, revoking any grant still held when the guard band before line 0 starts.
// - Also emits a one-cycle frame strobe that game logic uses as its frame tick.
// PARAMETERS
// - N_REQ        4    number of requesters (2..8)
// - YW           11   width of y coordinate
// - V_TOTAL      667  lines per frame (y counts 0..V_TOTAL-1)
// - GUARD_LINES  2    lines before wrap to 0 in which no grant may be held
// PORTS
// - clk        in   1      pixel-domain clock; y_crd/blank_in are synchronous to it
// - rst_n      in   1      asynchronous, active-low reset
// - y_crd      in   YW     current line number from vertical timer
// - blank_in   in   1      1 = vertical blank (non-visible lines)
// - req        in   N_REQ  level request per requester; held until granted and done
// - done       in   N_REQ  one-cycle pulse from the granted requester: transfer finished
// - ovr_clr    in   1      one-cycle pulse: clears ovr
// - gnt        out  N_REQ  one-hot (or zero) grant
// - win_open   out  1      1 while grants may be issued
// - frame_stb  out  1      one-cycle pulse on blank_in rising edge
// - ovr        out  N_REQ  sticky: requester's grant was revoked by window close
// BEHAVIOUR
// - Reset (async assert, sync release): gnt=0, win_open=0, frame_stb=0, ovr=0, state=CLOSED,
//   rr pointer=0, blank_in history register=1 (no spurious frame_stb after reset).
// - frame_stb: registered; =1 the cycle after blank_in sampled 1 with previous sample 0.
// - close_cond = blank_in==0 || y_crd >= V_TOTAL-GUARD_LINES.
// - States: CLOSED, IDLE, GRANT.
//   CLOSED: win_open=0. -> IDLE on the cycle frame_stb is asserted (window opens once per
//     frame; reset mid-blank therefore waits for the next frame).
//   IDLE: win_open=1. close_cond -> CLOSED. Else if any req: pick first set bit scanning from
//     rr pointer upward modulo N_REQ; gnt=that bit registered next cycle (1-cycle latency
//     req->gnt); -> GRANT.
//   GRANT: gnt held. done[g] -> gnt=0 next cycle, rr pointer=g+1 mod N_REQ, -> IDLE (one idle
//     cycle between grants minimum). close_cond without done -> gnt=0, ovr[g]<=1, rr=g+1,
//     -> CLOSED. done and close_cond same cycle: done wins (no ovr), -> CLOSED.
// - done on a non-granted index or while not in GRANT: ignored.
// - req dropped while granted: grant kept until done or close (requester owns release).
// - ovr_clr and new ovr set same cycle: set wins for that bit, others cleared.
// - gnt is never non-zero while win_open is 0; gnt is never non-zero during visible lines.
// - Requester that drops req before service loses its turn; no queuing.
// STRUCTURE
// - Shared package vga_pkg: V_TOTAL, V_VISIBLE, YW constants; typedef arb_state_t
//   {CLOSED, IDLE, GRANT}.
// - One sub-module rr_pick: combinational N_REQ-wide round-robin priority picker
//   (req, ptr -> one-hot, valid); index encode via function in package.
// TESTING
// - Reset asserted at y=620 blank=1, released y=625 -> frame_stb stays 0, gnt=0 until next
//   frame; at y=600 of next frame frame_stb=1 for exactly one cycle.
// - req=4'b1010 at window open, ptr=0 -> gnt=4'b0010 one cycle later; done[1] -> gnt=0, then
//   gnt=4'b1000; done[3] -> ptr wraps to 0.
// - All req held, each done 10 cycles after grant -> grant order 0,1,2,3,0,... across frames,
//   no requester granted twice before others.
// - Grant to 2 held with no done until y=665 (V_TOTAL-GUARD_LINES) -> gnt=0 same cycle+1,
//   ovr=4'b0100, win_open=0; ovr_clr pulse -> ovr=0.
// - done[2] and close_cond same cycle -> ovr stays 0, state CLOSED.
// - Visible-area stimulus (y=0..599, req=4'b1111) -> gnt==0 and win_open==0 throughout;
//   assertion: $onehot0(gnt) and !(|gnt && !win_open) every cycle.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared timing constants, arbiter state encoding and a one-hot index helper
// for the vertical-blank update-window logic.
package vga_pkg;

  localparam int unsigned YW          = 11;
  localparam int unsigned V_TOTAL     = 667;
  localparam int unsigned V_VISIBLE   = 600;
  localparam int unsigned GUARD_LINES = 2;

  // Widest requester vector the index helper handles.
  localparam int unsigned MAX_REQ = 8;
  localparam int unsigned IDX_W   = 3;

  typedef enum logic [1:0] {
    CLOSED = 2'd0,
    IDLE   = 2'd1,
    GRANT  = 2'd2
  } arb_state_t;

  // Encode a one-hot (or zero) vector to its bit index; zero maps to 0.
  function automatic logic [IDX_W-1:0] oh_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) begin
        idx = idx | IDX_W'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority picker.
// Scans req starting at index ptr and wrapping modulo N_REQ; returns the
// first set bit as a one-hot vector.
// Ports:
//   req     - request vector
//   ptr     - index that has highest priority this cycle
//   pick_c  - one-hot selection (zero when nothing requested)
//   valid_c - 1 when any request is present
module rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned PW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] pick_c,
  output logic             valid_c
);

  logic [PW-1:0] idx;

  // First hit wins; later hits are masked by valid_c.
  always_comb begin
    pick_c  = '0;
    valid_c = 1'b0;
    idx     = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = PW'((32'(ptr) + i) % N_REQ);
      if (!valid_c && req[idx]) begin
        pick_c[idx] = 1'b1;
        valid_c     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vblank_arbiter.sv
// Vertical-blank update-window arbiter.
// Shares the once-per-frame blank interval between N_REQ requesters that may
// only touch display memory while no lines are visible. Grants are issued
// round-robin, one at a time, and any grant still held when the guard band
// before line 0 starts is revoked and flagged in ovr. Also produces a
// one-cycle frame strobe on the rising edge of blank_in.
// Ports:
//   clk       - pixel-domain clock (y_crd/blank_in synchronous to it)
//   rst_n     - asynchronous active-low reset
//   y_crd     - current line number from the vertical timer
//   blank_in  - 1 during vertical blank
//   req       - level requests, held until granted and done
//   done      - one-cycle pulse from the granted requester
//   ovr_clr   - one-cycle pulse clearing ovr
//   gnt       - one-hot (or zero) grant
//   win_open  - 1 while grants may be issued
//   frame_stb - one-cycle pulse after blank_in rises
//   ovr       - sticky per-requester "grant revoked by window close"
module vblank_arbiter #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned YW          = vga_pkg::YW,
  parameter int unsigned V_TOTAL     = vga_pkg::V_TOTAL,
  parameter int unsigned GUARD_LINES = vga_pkg::GUARD_LINES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [YW-1:0]    y_crd,
  input  logic             blank_in,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] done,
  input  logic             ovr_clr,
  output logic [N_REQ-1:0] gnt,
  output logic             win_open,
  output logic             frame_stb,
  output logic [N_REQ-1:0] ovr
);

  import vga_pkg::*;

  localparam int unsigned   PW      = $clog2(N_REQ);
  localparam logic [YW-1:0] Y_CLOSE = YW'(V_TOTAL - GUARD_LINES);

  arb_state_t       state_q;
  arb_state_t       state_d;
  logic [N_REQ-1:0] gnt_d;
  logic [N_REQ-1:0] ovr_d;
  logic [N_REQ-1:0] pick_c;
  logic [PW-1:0]    ptr_q;
  logic [PW-1:0]    ptr_d;
  logic [PW-1:0]    g_idx_c;
  logic [PW-1:0]    g_next_c;
  logic             win_d;
  logic             blank_q;
  logic             valid_c;
  logic             close_c;
  logic             done_hit_c;

  // Window must be shut during visible lines and in the guard band before wrap.
  assign close_c = !blank_in || (y_crd >= Y_CLOSE);

  // Index of the current grant and the requester after it (rr pointer update).
  assign g_idx_c    = PW'(oh_to_idx(MAX_REQ'(gnt)));
  assign g_next_c   = (g_idx_c == PW'(N_REQ - 1)) ? '0 : g_idx_c + PW'(1);
  // Only a done from the granted requester counts.
  assign done_hit_c = |(done & gnt);

  rr_pick #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .pick_c  (pick_c),
    .valid_c (valid_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt;
    ptr_d   = ptr_q;
    // Clear first so a revocation in the same cycle still sets its bit.
    ovr_d   = ovr & ~{N_REQ{ovr_clr}};

    case (state_q)
      CLOSED: begin
        gnt_d = '0;
        // Only the blank rising edge opens the window, so a reset released
        // mid-blank waits for the following frame.
        if (frame_stb) begin
          state_d = IDLE;
        end
      end

      IDLE: begin
        gnt_d = '0;
        if (close_c) begin
          state_d = CLOSED;
        end else if (valid_c) begin
          gnt_d   = pick_c;
          state_d = GRANT;
        end
      end

      GRANT: begin
        if (done_hit_c) begin
          // A finished transfer is never flagged, even if the window closes now.
          gnt_d   = '0;
          ptr_d   = g_next_c;
          state_d = close_c ? CLOSED : IDLE;
        end else if (close_c) begin
          gnt_d   = '0;
          ovr_d   = ovr_d | gnt;
          ptr_d   = g_next_c;
          state_d = CLOSED;
        end
      end

      default: begin
        gnt_d   = '0;
        state_d = CLOSED;
      end
    endcase

    win_d = (state_d != CLOSED);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CLOSED;
      gnt       <= '0;
      ptr_q     <= '0;
      ovr       <= '0;
      win_open  <= 1'b0;
      frame_stb <= 1'b0;
      blank_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      gnt       <= gnt_d;
      ptr_q     <= ptr_d;
      ovr       <= ovr_d;
      win_open  <= win_d;
      frame_stb <= blank_in & ~blank_q;
      blank_q   <= blank_in;
    end
  end

endmodule
